// File: rtl/mult_pkg.sv
// Shared sizing helpers for the pipelined Wallace multiplier: 3:2 level count and the
// mapping of reduction levels onto pipeline stages.
package mult_pkg;

    function automatic int unsigned prod_w(int unsigned width);
        return 2 * width;
    endfunction

    function automatic int unsigned rows_after(int unsigned rows);
        return 2 * (rows / 3) + (rows % 3);
    endfunction

    // Rows entering reduction level `level` (level 0 = raw partial products).
    function automatic int unsigned rows_at(int unsigned width, int unsigned level);
        int unsigned n;
        n = width;
        for (int i = 0; i < 64; i++) begin
            if (i < int'(level)) n = rows_after(n);
        end
        return n;
    endfunction

    function automatic int unsigned csa_levels(int unsigned width);
        int unsigned n;
        int unsigned lv;
        n  = width;
        lv = 0;
        for (int i = 0; i < 64; i++) begin
            if (n > 2) begin
                n  = rows_after(n);
                lv = lv + 1;
            end
        end
        return lv;
    endfunction

    // Middle stage hosting a reduction level; spreads levels evenly over `mid` stages.
    function automatic int unsigned level_stage(int unsigned level, int unsigned levels,
                                                int unsigned mid);
        return (level * mid) / levels;
    endfunction

    // Valid-stage index of the register placed in front of level `pos`, or -1 if none.
    // Position `levels` is the register holding the two rows for the final adder.
    function automatic int cut_stage(int unsigned pos, int unsigned levels, int unsigned mid);
        if (mid == 0) return (pos == levels) ? 0 : -1;
        if (pos == 0) return 0;
        if (pos == levels ||
            level_stage(pos, levels, mid) != level_stage(pos - 1, levels, mid))
            return int'(level_stage(pos - 1, levels, mid)) + 1;
        return -1;
    endfunction

endpackage

// File: rtl/csa_row.sv
// N-bit 3:2 carry-save compressor: one sum row and one left-shifted carry row.
module csa_row #(
    parameter int unsigned N = 64
) (
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_y,
    input  logic [N-1:0] i_z,
    output logic [N-1:0] o_sum,
    output logic [N-1:0] o_carry
);

    logic [N-2:0] w_maj;

    assign o_sum   = i_x ^ i_y ^ i_z;
    // Majority out of the top bit would shift past the row, so it is never formed.
    assign w_maj   = (i_x[N-2:0] & i_y[N-2:0]) | (i_x[N-2:0] & i_z[N-2:0]) |
                     (i_y[N-2:0] & i_z[N-2:0]);
    assign o_carry = {w_maj, 1'b0};

endmodule

// File: rtl/pipelined_wallace_multiplier.sv
// Pipelined signed/unsigned Wallace-tree multiplier with valid/ready at both ends.
// Optional overflow output enabled by defining MULT_OVF_FLAG_EN.
module pipelined_wallace_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PIPE_STAGES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
`ifdef MULT_OVF_FLAG_EN
    ,
    output logic               overflow
`endif
);

    localparam int unsigned PROD_W = prod_w(WIDTH);
    localparam int unsigned LEVELS = csa_levels(WIDTH);
    localparam int unsigned MID    = PIPE_STAGES - 2;
    localparam int unsigned S      = PIPE_STAGES;

    logic [S-1:0]        r_v;
    logic [S-1:0]        w_ld;
    logic [S-1:0]        w_adv;
    logic [S-1:0]        w_vin;
    logic [S-1:0]        w_en;
    logic [S-2:0]        r_neg;
    logic [PROD_W-1:0]   r_product;

    // ---------------- handshake / valid chain ----------------
    always_comb begin
        w_ld  = '0;
        w_adv = '0;
        w_vin = '0;
        w_en  = '0;
        w_adv[S-1] = r_v[S-1] & out_ready;
        w_ld[S-1]  = ~r_v[S-1] | w_adv[S-1];
        for (int k = S - 2; k >= 0; k--) begin
            w_adv[k] = r_v[k] & w_ld[k+1];
            w_ld[k]  = ~r_v[k] | w_adv[k];
        end
        w_vin[0] = in_valid & w_ld[0] & ~flush;
        for (int k = 1; k < S; k++) w_vin[k] = r_v[k-1];
        w_en = w_ld & w_vin & {S{~flush}};
    end

    assign in_ready  = w_ld[0] & ~flush;
    assign out_valid = r_v[S-1];
    assign product   = r_product;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
        end else if (flush) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < S; k++) begin
                if (w_ld[k]) r_v[k] <= w_vin[k];
            end
        end
    end

    // ---------------- sign handling and partial products ----------------
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_neg;
    logic [WIDTH-1:0]  w_mag_a;
    logic [WIDTH-1:0]  w_mag_b;
    logic [PROD_W-1:0] w_pp [WIDTH];

    assign w_a_neg = is_signed & a[WIDTH-1];
    assign w_b_neg = is_signed & b[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
    assign w_mag_a = w_a_neg ? -a : a;
    assign w_mag_b = w_b_neg ? -b : b;
    assign w_neg   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

    for (genvar r = 0; r < WIDTH; r++) begin : g_pp
        assign w_pp[r] = w_mag_b[r] ? ({{WIDTH{1'b0}}, w_mag_a} << r) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg <= '0;
        end else begin
            if (w_en[0]) r_neg[0] <= w_neg;
            for (int k = 1; k < S - 1; k++) begin
                if (w_en[k]) r_neg[k] <= r_neg[k-1];
            end
        end
    end

    // ---------------- carry-save reduction tree ----------------
    logic [PROD_W-1:0] w_lin  [LEVELS+1][WIDTH];
    logic [PROD_W-1:0] w_lout [LEVELS][WIDTH];

    for (genvar p = 0; p <= LEVELS; p++) begin : g_pos
        logic [PROD_W-1:0] w_src [WIDTH];
        for (genvar r = 0; r < WIDTH; r++) begin : g_src
            if (p == 0) begin : g_from_pp
                assign w_src[r] = w_pp[r];
            end else begin : g_from_lvl
                assign w_src[r] = w_lout[p-1][r];
            end
        end
        if (cut_stage(p, LEVELS, MID) >= 0) begin : g_cut
            localparam int K = cut_stage(p, LEVELS, MID);
            logic [PROD_W-1:0] r_rows [WIDTH];
            always_ff @(posedge clk) begin
                if (w_en[K]) r_rows <= w_src;
            end
            for (genvar r = 0; r < WIDTH; r++) begin : g_out
                assign w_lin[p][r] = r_rows[r];
            end
        end else begin : g_thru
            for (genvar r = 0; r < WIDTH; r++) begin : g_out
                assign w_lin[p][r] = w_src[r];
            end
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned N_IN  = rows_at(WIDTH, l);
        localparam int unsigned N_TRI = N_IN / 3;
        localparam int unsigned N_REM = N_IN % 3;
        for (genvar t = 0; t < N_TRI; t++) begin : g_csa
            csa_row #(
                .N(PROD_W)
            ) u_csa (
                .i_x    (w_lin[l][3*t]),
                .i_y    (w_lin[l][3*t+1]),
                .i_z    (w_lin[l][3*t+2]),
                .o_sum  (w_lout[l][2*t]),
                .o_carry(w_lout[l][2*t+1])
            );
        end
        for (genvar j = 0; j < N_REM; j++) begin : g_rem
            assign w_lout[l][2*N_TRI+j] = w_lin[l][3*N_TRI+j];
        end
        for (genvar r = 2 * N_TRI + N_REM; r < WIDTH; r++) begin : g_zero
            assign w_lout[l][r] = '0;
        end
    end

    // ---------------- final add, negate, result register ----------------
    logic [PROD_W-1:0] w_sum;
    logic [PROD_W-1:0] w_res;

    assign w_sum = w_lin[LEVELS][0] + w_lin[LEVELS][1];
    assign w_res = r_neg[S-2] ? -w_sum : w_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_product <= '0;
        end else if (w_en[S-1]) begin
            r_product <= w_res;
        end
    end

`ifdef MULT_OVF_FLAG_EN
    logic [S-2:0] r_sgn;
    logic         r_ovf;
    logic         w_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sgn <= '0;
        end else begin
            if (w_en[0]) r_sgn[0] <= is_signed;
            for (int k = 1; k < S - 1; k++) begin
                if (w_en[k]) r_sgn[k] <= r_sgn[k-1];
            end
        end
    end

    // Signed results fit only if the upper half plus the sign bit is a pure sign extension.
    assign w_ovf = r_sgn[S-2] ? ~((&w_res[PROD_W-1:WIDTH-1]) | ~(|w_res[PROD_W-1:WIDTH-1]))
                              : (|w_res[PROD_W-1:WIDTH]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_en[S-1]) begin
            r_ovf <= w_ovf;
        end
    end

    assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_wallace_multiplier.sv
// Scoreboard bench for pipelined_wallace_multiplier (WIDTH=32, PIPE_STAGES=3).
module tb_pipelined_wallace_multiplier;

    localparam int W = 32;
    localparam int S = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           is_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
`ifdef MULT_OVF_FLAG_EN
    logic           overflow;
`endif

    pipelined_wallace_multiplier #(
        .WIDTH      (W),
        .PIPE_STAGES(S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .is_signed(is_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product)
`ifdef MULT_OVF_FLAG_EN
        ,
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] prod;
        logic        ovf;
    } exp_t;

    exp_t        q[$];
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          n_popped = 0;
    logic        bp_en    = 1'b0;
    int          bp_cnt   = 0;
    logic [63:0] last_exp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        if (s) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    function automatic logic ovf_of(input logic [63:0] p, input logic s);
        if (s) return !((p[63:31] == '0) || (p[63:31] == {33{1'b1}}));
        return p[63:32] != '0;
    endfunction

    // Present one op, push its expected result when the accepting edge is imminent.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                         input logic [63:0] exp_p);
        int guard;
        exp_t e;
        in_valid  = 1'b1;
        a         = ia;
        b         = ib;
        is_signed = is;
        guard     = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready stayed 0, required 1");
        end else begin
            e.prod   = exp_p;
            e.ovf    = ovf_of(exp_p, is);
            last_exp = exp_p;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((q.size() != 0 || out_valid) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    initial begin : monitor
        logic        have_held;
        logic [63:0] held;
        exp_t        e;
        have_held = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            if (have_held && out_valid) check("stall_hold", product, held);
            have_held = out_valid && !out_ready;
            held      = product;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got out_valid=1 product=0x%0h, required none",
                             product);
                end else begin
                    e = q.pop_front();
                    check("product", product, e.prod);
`ifdef MULT_OVF_FLAG_EN
                    check("overflow", {63'b0, overflow}, {63'b0, e.ovf});
`endif
                    n_popped++;
                end
            end
        end
    end

    // 0/1/1 out_ready pattern while backpressure is enabled.
    initial begin : bp_driver
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                out_ready = (bp_cnt % 3) != 0;
                bp_cnt++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        int seen;
        int popped0;
        logic [31:0] ra;
        logic [31:0] rb;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("reset_product", product, 64'd0);
`ifdef MULT_OVF_FLAG_EN
        check("reset_overflow", {63'b0, overflow}, 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Unsigned max, with latency measured from the accepting edge.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        check("latency", lat, 3);
        wait_drain();

        // Back-to-back directed corners.
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        issue(32'hFFFF_FFFF, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9);
        issue(32'hFFFF_FFFF, 32'h0000_0007, 1'b0, 64'h0000_0006_FFFF_FFF9);
        issue(32'hFFFF_FFFB, 32'h0000_0000, 1'b1, 64'h0000_0000_0000_0000);
        issue(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000);
        issue(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
        issue(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
        wait_drain();

        // Backpressure burst of 16 random ops.
        popped0 = n_popped;
        bp_cnt  = 0;
        bp_en   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ra = $urandom();
            rb = $urandom();
            issue(ra, rb, i[0], model(ra, rb, i[0]));
        end
        wait_drain();
        bp_en     = 1'b0;
        out_ready = 1'b1;
        check("bp_count", n_popped - popped0, 16);
        @(posedge clk);
        #1;

        // Flush with two ops in flight and a third presented during the flush cycle.
        in_valid  = 1'b1;
        is_signed = 1'b0;
        a         = 32'd3;
        b         = 32'd4;
        @(posedge clk);
        #1;
        a = 32'd5;
        b = 32'd6;
        @(posedge clk);
        #1;
        flush = 1'b1;
        a     = 32'd7;
        b     = 32'd8;
        @(negedge clk);
        check("flush_in_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        seen     = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_out_valid", seen, 0);
        check("flush_product_kept", product, last_exp);
        @(posedge clk);
        #1;

        // Reset with operations in flight.
        issue(32'd3, 32'd5, 1'b0, 64'd15);
        wait_drain();
        in_valid = 1'b1;
        a        = 32'd9;
        b        = 32'd9;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_product", product, 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_spurious", seen, 0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        issue(32'd6, 32'd7, 1'b1, 64'd42);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
